rx_deser_fifo: RTL and testbench
================================

Name: rx_deser_fifo

Overview:
Parametrised serial-to-parallel receive block for the WiFi PHY path, the next generation of the fixed 32-bit RX deserializer.
- Assembles a qualified serial bit stream into DATA_WIDTH words, in selectable bit order.
- Detects end-of-frame by an idle gap, flushes any partial tail word with its bit count, and buffers words in a FIFO with a valid/ready read port.
- Raises a maskable sticky interrupt to the AHB-side register block at end of frame.

Parameters:
- DATA_WIDTH, 32, word width in bits; at least 2.
- FIFO_DEPTH, 4, word slots; power of two, at least 2.
- IDLE_GAP, 8, consecutive idle cycles (bit_valid low) that terminate a frame; at least 1.
- MSB_FIRST, 0, 0 = first bit lands in bit 0; 1 = first bit lands in the MSB (shift-left).
- CNT_W, $clog2(DATA_WIDTH+1), derived width of the bit-count field.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- bit_valid  in  1  qualifies bit_in this cycle.
- bit_in  in  1  serial data bit.
- rd_valid  out  1  FIFO head holds a word.
- rd_ready  in  1  consumer accepts the head; a pop occurs when rd_valid and rd_ready are both high.
- rd_data  out  DATA_WIDTH  head word.
- rd_bits  out  CNT_W  number of valid bits in rd_data; DATA_WIDTH for a full word, 1..DATA_WIDTH-1 for a tail word.
- rd_last  out  1  head word is the last word of its frame.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- irq_en  in  1  interrupt enable.
- irq_clear  in  1  clears rx_irq and overflow.
- rx_irq  out  1  sticky end-of-frame interrupt.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM in IDLE; shift register, bit_cnt and gap_cnt are 0. Reset asserted mid-frame discards the partial word and all buffered words.
- States:
  - IDLE: on bit_valid, capture the bit, set bit_cnt=1, go to SHIFT.
  - SHIFT: on bit_valid, capture the bit and bit_cnt++. With bit_valid low, go to GAP with gap_cnt=1.
  - GAP: on bit_valid, capture the bit, clear gap_cnt, return to SHIFT. Otherwise gap_cnt++. When gap_cnt==IDLE_GAP, end the frame and go to IDLE.
- Full word: the cycle that captures bit DATA_WIDTH pushes {word, rd_bits=DATA_WIDTH, last=0} and sets bit_cnt=0. The push applies to a bit_valid in SHIFT or GAP.
- End of frame:
  - If bit_cnt!=0, push the tail word with upper bits zero, rd_bits=bit_cnt, last=1.
  - If bit_cnt==0, the last word already pushed is retro-marked last=1 if it is still in the FIFO; otherwise no marking.
  - frame_done pulses; rx_irq is set if irq_en.
- Bit order, MSB_FIRST=0: bit k of the word is the k-th received bit.
- Bit order, MSB_FIRST=1: the word shifts left, so the last-received bit is bit 0. Tail words are right-aligned.
- Latency: rd_valid rises on the cycle after the push into an empty FIFO. The FIFO is registered and has no combinational input-to-output path.
- Full FIFO:
  - A push with no simultaneous pop drops the word and sets overflow.
  - A push with a simultaneous pop is accepted and the level is unchanged.
- Empty FIFO: rd_ready is ignored; rd_data holds its last value. Pointers wrap modulo FIFO_DEPTH.
- Interrupt priority: set wins over irq_clear in the same cycle. irq_en low blocks the set but does not clear an already-set flag.
- overflow: cleared by irq_clear; a same-cycle new drop wins over the clear.

Decomposition:
- Shared package rx_deser_pkg holds:
  - FSM state localparams: IDLE, SHIFT, GAP.
  - Width helper localparams: CNT_W, the level width.
- One sub-module, rx_word_fifo: a synchronous FIFO.
  - Parameters: width DATA_WIDTH+CNT_W+1 and FIFO_DEPTH.
  - Interfaces: push/full, pop/empty, level, plus a mark_last strobe for the tail entry.

Test Plan (DATA_WIDTH=8, FIFO_DEPTH=4, IDLE_GAP=4 unless noted):
1. MSB_FIRST=0, 16 contiguous bits forming 0xA5 then 0x3C (LSB first), rd_ready=1 -> two words 0xA5 and 0x3C with rd_bits=8. Second word rd_last=1, frame_done pulses 4 idle cycles after the last bit, rx_irq=1 with irq_en=1.
2. MSB_FIRST=1, 11 bits 1,0,1,1,0,0,1,0, 1,1,0 -> words 0xB2 (rd_bits=8) and 0x06 (rd_bits=3, rd_last=1).
3. Idle gap of 3 cycles mid-word, then the remaining bits -> single 8-bit word and no frame_done; a gap of 4 cycles ends the frame.
4. rd_ready=0, 5 full words -> fifo_level=4, 5th word dropped, overflow=1. Then irq_clear -> overflow=0, rx_irq=0. Then pop all -> words 1..4 in order.
5. FIFO full with push and pop in the same cycle -> fifo_level stays 4, overflow stays 0. Also: irq_clear in the same cycle as frame end -> rx_irq=1.
6. Reset asserted after 5 bits of a word -> all outputs 0 immediately; next frame 0x5A is received cleanly with rd_bits=8.

Source files
------------

// File: rtl/rx_deser_pkg.sv
// Shared types and width helpers for the serial receive deserializer.
package rx_deser_pkg;

  // Frame assembly FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Width of a bit-count field able to hold 0..data_width.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Registered word FIFO with a strobe that flags the newest entry as
// end-of-frame. The entry MSB is the "last" flag.
module rx_word_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [LVL_W-1:0] level_o,
  input  logic             mark_last_i
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = cnt_q;
  // While empty, keep showing the entry that was popped last.
  assign head_o  = empty_o ? mem_q[rd_ptr_q - PTR_W'(1)] : mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; retro-mark hits the newest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (mark_last_i && !empty_o) mem_q[wr_ptr_q - PTR_W'(1)][WIDTH-1] <= 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rx_deser_fifo.sv
// Serial-to-parallel receiver: assembles qualified bits into words, ends a
// frame on an idle gap (flushing any partial tail), buffers words in a FIFO
// and raises a sticky end-of-frame interrupt.
module rx_deser_fifo
  import rx_deser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                bit_valid,
  input  logic                                bit_in,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [CNT_W-1:0]                    rd_bits,
  output logic                                rd_last,
  output logic [lvl_width(FIFO_DEPTH)-1:0]    fifo_level,
  input  logic                                irq_en,
  input  logic                                irq_clear,
  output logic                                rx_irq,
  output logic                                overflow,
  output logic                                frame_done
);
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam int EW    = DATA_WIDTH + CNT_W + 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_cap;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d, gap_inc;
  logic                  push, eof, mark, drop, pop, full, empty;
  logic                  last_ok_q, frame_done_q, rx_irq_q, overflow_q;
  logic [EW-1:0]         push_ent, head;

  // Word with the incoming bit folded in; a zero bit count starts a fresh word.
  always_comb begin
    sr_cap = (bit_cnt_q == '0) ? '0 : sr_q;
    if (MSB_FIRST) begin
      sr_cap = {sr_cap[DATA_WIDTH-2:0], bit_in};
    end else begin
      for (int k = 0; k < DATA_WIDTH; k++)
        if (bit_cnt_q == CNT_W'(k)) sr_cap[k] = bit_in;
    end
  end

  // Idle count this cycle would reach if the gap continues.
  assign gap_inc = (state_q == GAP) ? gap_q + GAP_W'(1) : GAP_W'(1);

  // Frame FSM next state: capture, full-word push, idle-gap end of frame.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    push      = 1'b0;
    push_ent  = '0;
    eof       = 1'b0;
    mark      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_valid) begin
          sr_d      = sr_cap;
          bit_cnt_d = CNT_W'(1);
          gap_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT, GAP: begin
        if (bit_valid) begin
          sr_d    = sr_cap;
          gap_d   = '0;
          state_d = SHIFT;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            push      = 1'b1;
            push_ent  = {1'b0, CNT_W'(DATA_WIDTH), sr_cap};
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (gap_inc == GAP_W'(IDLE_GAP)) begin
          eof       = 1'b1;
          state_d   = IDLE;
          gap_d     = '0;
          bit_cnt_d = '0;
          sr_d      = '0;
          if (bit_cnt_q != '0) begin
            push     = 1'b1;
            push_ent = {1'b1, bit_cnt_q, sr_q};
          end else begin
            // Only tag the final full word if it actually made it into the FIFO.
            mark = last_ok_q;
          end
        end else begin
          state_d = GAP;
          gap_d   = gap_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = !empty && rd_ready;
  assign drop = push && full && !pop;

  rx_word_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (lvl_width(FIFO_DEPTH))
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_ent),
    .full_o      (full),
    .pop_i       (rd_ready),
    .empty_o     (empty),
    .head_o      (head),
    .level_o     (fifo_level),
    .mark_last_i (mark)
  );

  // FSM state and status flags; a new set beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      last_ok_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rx_irq_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_q        <= gap_d;
      if (push) last_ok_q <= !drop;
      frame_done_q <= eof;
      if (eof && irq_en)  rx_irq_q <= 1'b1;
      else if (irq_clear) rx_irq_q <= 1'b0;
      if (drop)           overflow_q <= 1'b1;
      else if (irq_clear) overflow_q <= 1'b0;
    end
  end

  assign rd_valid                   = !empty;
  assign {rd_last, rd_bits, rd_data} = head;
  assign frame_done                 = frame_done_q;
  assign rx_irq                     = rx_irq_q;
  assign overflow                   = overflow_q;

endmodule

// File: tb/tb_rx_deser_fifo.sv
// Bench for rx_deser_fifo: an LSB-first and an MSB-first instance share one
// bit stream; a frame/queue model predicts every cycle, and directed tests pin
// popped words to hand-computed values.
module tb_rx_deser_fifo;
  localparam int DW = 8, DEP = 4, GAPN = 4, CW = 4, LW = 3;

  logic clk = 1'b0, reset = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic rd_ready = 1'b0, irq_en = 1'b0, irq_clear = 1'b0;
  logic [1:0]         rv, rl, irq, ovf, fd;
  logic [1:0][DW-1:0] rdat;
  logic [1:0][CW-1:0] rbits;
  logic [1:0][LW-1:0] lvl;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rx_deser_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .IDLE_GAP(GAPN), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .rd_valid(rv[0]), .rd_ready(rd_ready), .rd_data(rdat[0]), .rd_bits(rbits[0]),
    .rd_last(rl[0]), .fifo_level(lvl[0]), .irq_en(irq_en), .irq_clear(irq_clear),
    .rx_irq(irq[0]), .overflow(ovf[0]), .frame_done(fd[0]));

  rx_deser_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .IDLE_GAP(GAPN), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .rd_valid(rv[1]), .rd_ready(rd_ready), .rd_data(rdat[1]), .rd_bits(rbits[1]),
    .rd_last(rl[1]), .fifo_level(lvl[1]), .irq_en(irq_en), .irq_clear(irq_clear),
    .rx_irq(irq[1]), .overflow(ovf[1]), .frame_done(fd[1]));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- model: raw arrival bits per word, list-ordered FIFO
  typedef struct {logic [DW-1:0] raw; int n; bit last; int id;} ent_t;
  typedef struct {logic [DW-1:0] d; int b; bit l;} pop_t;
  ent_t mq[$];
  pop_t log0[$], log1[$];
  logic [DW-1:0] m_raw;
  int m_nb, m_idle, m_last_id, m_next_id;
  bit m_active, m_fd, m_irq, m_ovf;

  // raw[k] is the k-th received bit; MSB-first right-aligns in arrival order.
  function automatic logic [DW-1:0] render(input logic [DW-1:0] raw, input int n, input bit msb);
    logic [DW-1:0] w = '0;
    if (!msb) return raw;
    for (int k = 0; k < n; k++) w[n-1-k] = raw[k];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_raw = '0; m_nb = 0; m_idle = 0; m_last_id = -1; m_next_id = 0;
    m_active = 0; m_fd = 0; m_irq = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    ent_t e;
    bit have = 0, eof = 0, drop = 0;
    if (!reset) begin model_reset(); return; end
    if (bit_valid) begin
      m_raw[m_nb] = bit_in; m_nb++; m_active = 1; m_idle = 0;
      if (m_nb == DW) begin
        e = '{m_raw, DW, 1'b0, m_next_id}; have = 1; m_nb = 0; m_raw = '0;
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle == GAPN) begin
        eof = 1; m_active = 0; m_idle = 0;
        if (m_nb != 0) begin
          e = '{m_raw, m_nb, 1'b1, m_next_id}; have = 1; m_nb = 0; m_raw = '0;
        end
      end
    end
    if (mq.size() > 0 && rd_ready) mq.delete(0);
    if (eof && !have)
      foreach (mq[i]) if (mq[i].id == m_last_id) mq[i].last = 1;
    if (have) begin
      if (mq.size() < DEP) begin mq.push_back(e); m_last_id = e.id; end
      else begin drop = 1; m_last_id = -1; end
      m_next_id++;
    end
    m_fd = eof;
    if (eof && irq_en) m_irq = 1; else if (irq_clear) m_irq = 0;
    if (drop) m_ovf = 1; else if (irq_clear) m_ovf = 0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      string t = (m == 0) ? "lsb" : "msb";
      chk({t, ".rd_valid"}, rv[m], int'(mq.size() > 0));
      chk({t, ".fifo_level"}, lvl[m], mq.size());
      chk({t, ".frame_done"}, fd[m], m_fd);
      chk({t, ".rx_irq"}, irq[m], m_irq);
      chk({t, ".overflow"}, ovf[m], m_ovf);
      if (mq.size() > 0) begin
        chk({t, ".rd_data"}, rdat[m], render(mq[0].raw, mq[0].n, bit'(m)));
        chk({t, ".rd_bits"}, rbits[m], mq[0].n);
        chk({t, ".rd_last"}, rl[m], mq[0].last);
      end
    end
  end

  // ---------------- stimulus helpers (inputs change 2 time units after the edge)
  task automatic tick();
    if (rv[0] && rd_ready) log0.push_back('{rdat[0], int'(rbits[0]), rl[0]});
    if (rv[1] && rd_ready) log1.push_back('{rdat[1], int'(rbits[1]), rl[1]});
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; bit_in = b; tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) send_bit(v[k]);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0; bit_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain(input int n);
    bit_valid = 1'b0; rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  task automatic expect_pop(input int m, input string nm, input int d, input int b, input int l);
    pop_t p;
    if ((m == 0 && log0.size() == 0) || (m == 1 && log1.size() == 0)) begin
      tests++; fails++;
      $display("FAIL %s: no word popped, expected %0h", nm, d);
      return;
    end
    if (m == 0) begin p = log0[0]; log0.delete(0); end
    else begin p = log1[0]; log1.delete(0); end
    chk({nm, ".data"}, p.d, d);
    chk({nm, ".bits"}, p.b, b);
    chk({nm, ".last"}, p.l, l);
  endtask

  task automatic chk_zero(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, ".rd_valid"}, rv[m], 0);
      chk({nm, ".rd_data"}, rdat[m], 0);
      chk({nm, ".rd_bits"}, rbits[m], 0);
      chk({nm, ".rd_last"}, rl[m], 0);
      chk({nm, ".fifo_level"}, lvl[m], 0);
      chk({nm, ".rx_irq"}, irq[m], 0);
      chk({nm, ".overflow"}, ovf[m], 0);
      chk({nm, ".frame_done"}, fd[m], 0);
    end
  endtask

  task automatic clear_logs();
    log0.delete(); log1.delete();
  endtask

  initial begin
    logic [7:0] t2 [11];
    t2 = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
    model_reset();
    clear_logs();
    irq_en = 1'b1;
    tick(); tick();
    chk_zero("reset");
    reset = 1'b1;

    // 1: two LSB-first words, retro-marked last, frame_done after 4 idles
    clear_logs();
    send_byte(8'hA5); send_byte(8'h3C);
    idle(3); chk("t1.fd_early", fd[0], 0);
    idle(1); chk("t1.fd", fd[0], 1); chk("t1.irq", irq[0], 1); chk("t1.level", lvl[0], 2);
    idle(1); chk("t1.fd_pulse", fd[0], 0);
    drain(3);
    expect_pop(0, "t1.lsb0", 'hA5, 8, 0); expect_pop(0, "t1.lsb1", 'h3C, 8, 1);
    expect_pop(1, "t1.msb0", 'hA5, 8, 0); expect_pop(1, "t1.msb1", 'h3C, 8, 1);
    chk("t1.extra", log0.size() + log1.size(), 0);

    // 2: 11 bits -> full word plus 3-bit tail
    clear_logs();
    for (int i = 0; i < 11; i++) send_bit(t2[i][0]);
    idle(4); chk("t2.fd", fd[0], 1);
    drain(3);
    expect_pop(1, "t2.msb0", 'hB2, 8, 0); expect_pop(1, "t2.msb1", 'h06, 3, 1);
    expect_pop(0, "t2.lsb0", 'h4D, 8, 0); expect_pop(0, "t2.lsb1", 'h03, 3, 1);

    // 3: 3-idle gap mid-word keeps the frame; irq_en low leaves rx_irq set
    clear_logs();
    irq_en = 1'b0;
    for (int k = 0; k < 5; k++) send_bit(k == 1 || k == 2 || k == 4);
    idle(3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("t3.level", lvl[0], 1); chk("t3.no_fd", fd[0], 0);
    idle(4); chk("t3.fd", fd[0], 1); chk("t3.irq_held", irq[0], 1);
    drain(2);
    expect_pop(0, "t3.lsb", 'h96, 8, 1);
    irq_en = 1'b1;

    // 4: overflow on the 5th word, clear, then ordered drain
    clear_logs();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    idle(4);
    chk("t4.level", lvl[0], 4); chk("t4.ovf", ovf[0], 1); chk("t4.irq", irq[0], 1);
    irq_clear = 1'b1; tick(); irq_clear = 1'b0;
    chk("t4.ovf_clr", ovf[0], 0); chk("t4.irq_clr", irq[0], 0);
    drain(5);
    expect_pop(0, "t4.w1", 'h11, 8, 0); expect_pop(0, "t4.w2", 'h22, 8, 0);
    expect_pop(0, "t4.w3", 'h33, 8, 0); expect_pop(0, "t4.w4", 'h44, 8, 0);
    expect_pop(1, "t4.m1", 'h88, 8, 0);
    chk("t4.extra", log0.size(), 0);

    // 5: push+pop on a full FIFO; irq set beats a same-cycle clear
    clear_logs();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("t5.full", lvl[0], 4);
    for (int k = 0; k < 7; k++) send_bit(k == 0 || k == 2);
    rd_ready = 1'b1; send_bit(1'b0); rd_ready = 1'b0;
    chk("t5.level", lvl[0], 4); chk("t5.ovf", ovf[0], 0);
    idle(3); irq_clear = 1'b1; idle(1); irq_clear = 1'b0;
    chk("t5.irq", irq[0], 1); chk("t5.fd", fd[0], 1);
    drain(5);
    expect_pop(0, "t5.w1", 'h01, 8, 0); expect_pop(0, "t5.w2", 'h02, 8, 0);
    expect_pop(0, "t5.w3", 'h03, 8, 0); expect_pop(0, "t5.w4", 'h04, 8, 0);
    expect_pop(0, "t5.w5", 'h05, 8, 1);

    // 6: asynchronous reset mid-word, then a clean frame
    clear_logs();
    send_byte(8'h77); idle(4);
    chk("t6.pre_level", lvl[0], 1); chk("t6.pre_irq", irq[0], 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    chk_zero("t6.reset");
    bit_valid = 1'b0; bit_in = 1'b0;
    tick();
    reset = 1'b1;
    send_byte(8'h5A); idle(4);
    chk("t6.fd", fd[0], 1);
    drain(2);
    expect_pop(0, "t6.lsb", 'h5A, 8, 1); expect_pop(1, "t6.msb", 'h5A, 8, 1);
    chk("t6.extra", log0.size() + log1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    tests++; fails++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
